// File: rtl/snake_if.sv
// Button/heading bundle between the input panel and the snake direction register.
// Ports: up/down/left/right async button levels in, direction 2-bit heading out.
interface snake_if;
   logic       up;
   logic       down;
   logic       left;
   logic       right;
   logic [1:0] direction;

   modport master (
      output up,
      output down,
      output left,
      output right,
      input  direction
   );

   modport slave (
      input  up,
      input  down,
      input  left,
      input  right,
      output direction
   );
endinterface

// File: rtl/snake_control.sv
// Snake heading register: sync, optional debounce, edge detect, reversal reject.
// Ports: clk, reset (async active-low), sif.slave (buttons in, direction out).
module snake_control #(
   parameter int         SYNC_STAGES     = 2,
   parameter int         DEBOUNCE_CYCLES = 0,
   parameter logic [1:0] RESET_DIR       = 2'b00
) (
   input  logic   clk,
   input  logic   reset,
   snake_if.slave sif
);

   // Presses are masked until the input path has flushed after reset,
   // so a button held through reset release never counts as a press.
   localparam int WARM = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
   localparam int WW   = $clog2(WARM + 1);

   logic [3:0]    w_btn;
   logic [3:0]    r_sync [SYNC_STAGES];
   logic [3:0]    w_lvl;
   logic [3:0]    r_prev;
   logic [3:0]    r_press;
   logic [WW-1:0] r_warm;
   logic          w_ready;
   logic [1:0]    r_dir;
   logic [1:0]    w_next;

   // bit 0 up, 1 down, 2 left, 3 right
   assign w_btn = {sif.right, sif.left, sif.down, sif.up};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            r_sync[i] <= '0;
      end else begin
         r_sync[0] <= w_btn;
         for (int i = 1; i < SYNC_STAGES; i++)
            r_sync[i] <= r_sync[i-1];
      end
   end

   generate
      if (DEBOUNCE_CYCLES > 0) begin : g_db
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         logic [3:0]    r_lvl;
         logic [CW-1:0] r_cnt [4];

         // Counter runs only while the synced level disagrees
         // with the accepted level; any agreement reloads it.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_lvl <= '0;
               for (int b = 0; b < 4; b++)
                  r_cnt[b] <= '0;
            end else begin
               for (int b = 0; b < 4; b++) begin
                  if (r_sync[SYNC_STAGES-1][b] != r_lvl[b]) begin
                     if (r_cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        r_lvl[b] <= r_sync[SYNC_STAGES-1][b];
                        r_cnt[b] <= '0;
                     end else begin
                        r_cnt[b] <= r_cnt[b] + 1'b1;
                     end
                  end else begin
                     r_cnt[b] <= '0;
                  end
               end
            end
         end

         assign w_lvl = r_lvl;
      end else begin : g_nodb
         assign w_lvl = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   assign w_ready = (r_warm == WW'(WARM));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_warm  <= '0;
         r_prev  <= '0;
         r_press <= '0;
      end else begin
         if (!w_ready)
            r_warm <= r_warm + 1'b1;
         r_prev  <= w_lvl;
         r_press <= w_ready ? (w_lvl & ~r_prev) : 4'b0000;
      end
   end

   // Reversals are judged against the registered heading only;
   // first valid press in up/down/left/right order wins.
   always_comb begin
      w_next = r_dir;
      if (r_press[0] && r_dir != 2'b01)
         w_next = 2'b00;
      else if (r_press[1] && r_dir != 2'b00)
         w_next = 2'b01;
      else if (r_press[2] && r_dir != 2'b11)
         w_next = 2'b10;
      else if (r_press[3] && r_dir != 2'b10)
         w_next = 2'b11;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_dir <= RESET_DIR;
      else
         r_dir <= w_next;
   end

   assign sif.direction = r_dir;

endmodule

// File: tb/tb_snake_control.sv
// Directed checks for snake_control: reversal reject, priority, latency, reset.
// Drives buttons on falling edges through snake_if; checks on falling edges.
module tb_snake_control;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;

   snake_if sif ();

   snake_control #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (0),
      .RESET_DIR       (2'b00)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sif   (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] btn;
      int         hold;
      logic [1:0] exp;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string nm, input logic [1:0] act,
                      input logic [1:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %b want %b", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_total++;
      if (act != exp)
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic drive(input logic [3:0] b);
      sif.up    = b[0];
      sif.down  = b[1];
      sif.left  = b[2];
      sif.right = b[3];
   endtask

   task automatic press(input logic [3:0] b, input int hold);
      @(negedge clk);
      drive(b);
      repeat (hold) @(negedge clk);
      drive(4'b0000);
      repeat (8) @(negedge clk);
   endtask

   initial begin
      int         changes;
      logic [1:0] prev;

      n_pass  = 0;
      n_total = 0;
      drive(4'b0000);
      reset = 1'b0;

      // bit 0 up, 1 down, 2 left, 3 right
      vecs[0] = '{"down_rev_from_up",   4'b0010, 1, 2'b00};
      vecs[1] = '{"right_from_up",      4'b1000, 1, 2'b11};
      vecs[2] = '{"left_rev_from_rt",   4'b0100, 1, 2'b11};
      vecs[3] = '{"down_from_right",    4'b0010, 1, 2'b01};
      vecs[4] = '{"up_rev_from_down",   4'b0001, 1, 2'b01};
      vecs[5] = '{"left_from_down",     4'b0100, 1, 2'b10};
      vecs[6] = '{"right_rev_from_lt",  4'b1000, 1, 2'b10};
      vecs[7] = '{"up_right_from_left", 4'b1001, 1, 2'b00};
      vecs[8] = '{"down_left_from_up",  4'b0110, 1, 2'b10};
      vecs[9] = '{"up_from_left",       4'b0001, 1, 2'b00};

      repeat (3) @(negedge clk);
      chk("in_reset", sif.direction, 2'b00);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      chk("after_reset", sif.direction, 2'b00);

      for (int i = 0; i < 10; i++) begin
         press(vecs[i].btn, vecs[i].hold);
         chk(vecs[i].name, sif.direction, vecs[i].exp);
      end

      // long hold from UP: exactly one update
      changes = 0;
      prev    = sif.direction;
      drive(4'b1000);
      for (int c = 0; c < 28; c++) begin
         if (c == 20)
            drive(4'b0000);
         @(negedge clk);
         if (sif.direction !== prev)
            changes++;
         prev = sif.direction;
      end
      chk_int("hold_changes", changes, 1);
      chk("hold_final", sif.direction, 2'b11);
      press(4'b0001, 1);
      chk("up_after_hold", sif.direction, 2'b00);

      // latency: change lands on the 4th rising edge
      @(negedge clk);
      drive(4'b0100);
      @(posedge clk);
      @(negedge clk);
      drive(4'b0000);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("lat_edge3", sif.direction, 2'b00);
      @(posedge clk);
      @(negedge clk);
      chk("lat_edge4", sif.direction, 2'b10);
      repeat (4) @(negedge clk);

      press(4'b0010, 1);
      chk("down_pre_reset", sif.direction, 2'b01);

      // async reset between edges with right held throughout
      @(negedge clk);
      drive(4'b1000);
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset", sif.direction, 2'b00);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      chk("held_thru_reset", sif.direction, 2'b00);
      drive(4'b0000);
      repeat (6) @(negedge clk);
      chk("release_no_effect", sif.direction, 2'b00);
      press(4'b1000, 1);
      chk("repress_right", sif.direction, 2'b11);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
